// File: rtl/otmb_virtex6_if.sv
// VME bus bundle for the OTMB control block: address, command strobes,
// geographic slot and reply lines. The data bus stays a top-level inout.
`timescale 1ns/1ps
interface otmb_virtex6_if;
   logic [23:1] vme_a;
   logic [10:0] _vme_cmd;
   logic [6:0]  _vme_geo;
   logic [6:0]  vme_reply;

   modport master (output vme_a, output _vme_cmd, output _vme_geo, input vme_reply);
   modport slave  (input vme_a, input _vme_cmd, input _vme_geo, output vme_reply);
endinterface

// File: rtl/otmb_virtex6.sv
// OTMB Virtex-6 board controller: heartbeat, power-up sequencing and a small
// VME register slave (IDLE -> ACCESS -> ACK) driving board enables and LEDs.
`timescale 1ns/1ps
module otmb_virtex6 #(
   parameter logic [15:0] FW_ID        = 16'h6EB0,
   parameter int          HB_BIT       = 24,
   parameter int          PWRUP_CYCLES = 16
) (
   input  logic          tmb_clock0,
   input  logic          reset,
   otmb_virtex6_if.slave vme,
   inout  wire  [15:0]   vme_d,
   input  logic [8:7]    set_sw,
   input  logic          qpll_lock,
   input  logic          qpll_err,
   output logic [4:0]    cfeb_clock_en,
   output logic          cfeb_oe,
   output logic          alct_clock_en,
   output logic          _dmb_oe,
   output logic [4:0]    step,
   output logic          qpll_nrst,
   output logic [7:0]    led_fp,
   output logic [9:1]    testled
);

   localparam int              PU_W   = $clog2(PWRUP_CYCLES + 1);
   localparam logic [PU_W-1:0] PU_MAX = PU_W'(PWRUP_CYCLES);

   localparam logic [7:0] OFF_ID   = 8'h00;
   localparam logic [7:0] OFF_LED  = 8'h02;
   localparam logic [7:0] OFF_CFG  = 8'h04;
   localparam logic [7:0] OFF_STAT = 8'h06;
   localparam logic [7:0] OFF_STEP = 8'h08;
   localparam logic [7:0] OFF_HB   = 8'h0A;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} vme_state_e;

   vme_state_e      state_q, state_d;
   logic [31:0]     hb_cnt_q;
   logic [PU_W-1:0] pu_cnt_q, pu_cnt_d;
   logic            ready_q;
   logic            lock_q, err_q;
   logic            as_meta_q, as_sync_q, as_last_q;
   logic            wr_meta_q, wr_sync_q;
   logic [7:0]      off_q;
   logic            wr_q;
   logic [15:0]     wdata_q, rd_data_q;
   logic [15:0]     led_reg_q, cfg_reg_q, step_reg_q;
   logic [15:0]     rd_mux;
   logic            start;
   logic            board_sel, as_fall, is_wr_now, dtack, rd_drive;
   logic [7:0]      offset;
   logic            unused_pins;

   function automatic logic wr_mapped(input logic [7:0] off);
      return (off == OFF_LED) || (off == OFF_CFG) || (off == OFF_STEP);
   endfunction

   assign board_sel = (vme.vme_a[23:19] == ~vme._vme_geo[4:0]);
   assign offset    = {vme.vme_a[7:1], 1'b0};
   assign as_fall   = as_last_q & ~as_sync_q;
   assign is_wr_now = ~wr_sync_q;

   assign pu_cnt_d = (pu_cnt_q == PU_MAX) ? pu_cnt_q : pu_cnt_q + PU_W'(1);

   always_ff @(posedge tmb_clock0 or negedge reset) begin
      if (!reset) begin
         hb_cnt_q <= '0;
         pu_cnt_q <= '0;
         ready_q  <= 1'b0;
         lock_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         hb_cnt_q <= hb_cnt_q + 32'd1;
         pu_cnt_q <= pu_cnt_d;
         ready_q  <= (pu_cnt_d == PU_MAX);
         lock_q   <= qpll_lock;
         err_q    <= qpll_err;
      end
   end

   always_ff @(posedge tmb_clock0 or negedge reset) begin
      if (!reset) begin
         // NOTE: strobe synchronizers reset to the idle-high level so release never fakes an _as edge.
         as_meta_q <= 1'b1;
         as_sync_q <= 1'b1;
         as_last_q <= 1'b1;
         wr_meta_q <= 1'b1;
         wr_sync_q <= 1'b1;
      end else begin
         as_meta_q <= vme._vme_cmd[0];
         as_sync_q <= as_meta_q;
         as_last_q <= as_sync_q;
         wr_meta_q <= vme._vme_cmd[1];
         wr_sync_q <= wr_meta_q;
      end
   end

   always_ff @(posedge tmb_clock0 or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            // Unmapped writes are refused here so they leave no trace at all.
            if (as_fall && board_sel && (!is_wr_now || wr_mapped(offset))) begin
               state_d = ACCESS;
               start   = 1'b1;
            end
         end
         ACCESS:  state_d = ACK;
         ACK:     if (as_sync_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (off_q)
         OFF_ID:   rd_mux = FW_ID;
         OFF_LED:  rd_mux = led_reg_q;
         OFF_CFG:  rd_mux = cfg_reg_q;
         OFF_STAT: rd_mux = {10'b0, set_sw, err_q, lock_q, ready_q, 1'b1};
         OFF_STEP: rd_mux = step_reg_q;
         OFF_HB:   rd_mux = hb_cnt_q[31:16];
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge tmb_clock0 or negedge reset) begin
      if (!reset) begin
         off_q      <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
         led_reg_q  <= '0;
         cfg_reg_q  <= 16'h00FF;
         step_reg_q <= '0;
      end else begin
         if (start) begin
            off_q   <= offset;
            wr_q    <= is_wr_now;
            wdata_q <= vme_d;
         end
         if (state_q == ACCESS) begin
            if (wr_q) begin
               case (off_q)
                  OFF_LED:  led_reg_q  <= wdata_q;
                  OFF_CFG:  cfg_reg_q  <= wdata_q;
                  OFF_STEP: step_reg_q <= wdata_q;
                  default:  ;
               endcase
            end else begin
               rd_data_q <= rd_mux;
            end
         end
      end
   end

   assign dtack         = (state_q == ACK);
   assign rd_drive      = dtack & ~wr_q;
   assign vme.vme_reply = {5'b0, rd_drive, dtack};
   assign vme_d         = rd_drive ? rd_data_q : 16'hzzzz;

   assign led_fp        = led_reg_q[7:0];
   assign cfeb_clock_en = cfg_reg_q[4:0];
   assign cfeb_oe       = cfg_reg_q[5];
   assign alct_clock_en = cfg_reg_q[6];
   assign _dmb_oe       = ~cfg_reg_q[7];
   assign step          = step_reg_q[4:0];
   assign qpll_nrst     = ready_q;
   assign testled       = {5'b0, err_q, lock_q, ready_q, hb_cnt_q[HB_BIT]};

   assign unused_pins = ^{vme.vme_a[18:8], vme._vme_cmd[10:2], vme._vme_geo[6:5]};

endmodule

// File: tb/tb_otmb_virtex6.sv
// Self-checking bench for otmb_virtex6: directed VME cycles plus random
// traffic scored against an offset-keyed register model.
`timescale 1ns/1ps
module tb_otmb_virtex6;
   localparam int          HB = 4;
   localparam logic [15:0] FW = 16'h6EB0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [8:7]  set_sw;
   logic        qpll_lock, qpll_err;
   logic [4:0]  cfeb_clock_en, step;
   logic        cfeb_oe, alct_clock_en, _dmb_oe, qpll_nrst;
   logic [7:0]  led_fp;
   logic [9:1]  testled;
   logic [20:0] pins;
   wire  [15:0] vme_d;
   logic        tb_drv;
   logic [15:0] tb_dat;

   int          n_cmp, n_err;
   int unsigned cyc;
   logic [15:0] m_rw [logic [7:0]];

   otmb_virtex6_if vif ();

   otmb_virtex6 #(.FW_ID(FW), .HB_BIT(HB), .PWRUP_CYCLES(16)) dut (
      .tmb_clock0    (clk),
      .reset         (rst_n),
      .vme           (vif),
      .vme_d         (vme_d),
      .set_sw        (set_sw),
      .qpll_lock     (qpll_lock),
      .qpll_err      (qpll_err),
      .cfeb_clock_en (cfeb_clock_en),
      .cfeb_oe       (cfeb_oe),
      .alct_clock_en (alct_clock_en),
      ._dmb_oe       (_dmb_oe),
      .step          (step),
      .qpll_nrst     (qpll_nrst),
      .led_fp        (led_fp),
      .testled       (testled)
   );

   assign vme_d = tb_drv ? tb_dat : 16'hzzzz;
   assign pins  = {led_fp, step, alct_clock_en, cfeb_oe, cfeb_clock_en, _dmb_oe};

   always #12.5 clk = ~clk;

   // Clocks elapsed since reset release: the heartbeat and power-up reference.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      m_rw.delete();
      m_rw[8'h02] = 16'h0000;
      m_rw[8'h04] = 16'h00FF;
      m_rw[8'h08] = 16'h0000;
   endfunction

   function automatic logic [15:0] m_read(input logic [7:0] off);
      if (m_rw.exists(off)) return m_rw[off];
      case (off)
         8'h00:   return FW;
         8'h06:   return {10'b0, set_sw, qpll_err, qpll_lock, (cyc >= 16), 1'b1};
         8'h0A:   return 16'(cyc >> 16);
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [20:0] m_pins();
      logic [15:0] led, cfg, stp;
      led = m_rw[8'h02];
      cfg = m_rw[8'h04];
      stp = m_rw[8'h08];
      return {led[7:0], stp[4:0], cfg[6:0], ~cfg[7]};
   endfunction

   function automatic logic [23:1] mk_addr(input logic [4:0] slot, input logic [7:0] off);
      logic [31:0] r;
      r = $urandom();
      return {slot, r[10:0], off[7:1]};
   endfunction

   task automatic vme_xact(input logic [23:1] a, input logic [6:0] geo, input bit wr,
                           input logic [15:0] wd, input string tag);
      logic [4:0]  slot, want;
      logic [7:0]  off;
      logic [15:0] exp_rd, rd;
      logic [31:0] r;
      bit          exp_ack, acked;
      logic        rd_en;
      int          lat;
      slot    = a[23:19];
      want    = ~geo[4:0];
      off     = {a[7:1], 1'b0};
      exp_ack = (slot == want) && (!wr || m_rw.exists(off));
      exp_rd  = m_read(off);
      @(negedge clk);
      r = $urandom();
      vif.vme_a    = a;
      vif._vme_geo = geo;
      vif._vme_cmd = {r[8:0], ~wr, 1'b1};
      tb_drv = wr;
      tb_dat = wd;
      @(negedge clk);
      vif._vme_cmd[0] = 1'b0;
      acked = 0; lat = 0; rd = '0; rd_en = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (vif.vme_reply[0] && !acked) begin
            acked = 1; lat = k; rd = vme_d; rd_en = vif.vme_reply[1];
         end
      end
      check($sformatf("%s ack", tag), acked, exp_ack);
      if (exp_ack) begin
         // _as pin falls, two synchronizer clocks, then two clocks to dtack.
         check($sformatf("%s latency", tag), lat, 4);
         check($sformatf("%s rd_en", tag), rd_en, !wr);
         if (!wr) check($sformatf("%s rdata", tag), rd, exp_rd);
         if (wr) m_rw[off] = wd;
      end
      vif._vme_cmd[0] = 1'b1;
      repeat (3) @(negedge clk);
      check($sformatf("%s release", tag), vif.vme_reply, 0);
      tb_drv = 1'b0;
      check($sformatf("%s pins", tag), pins, m_pins());
   endtask

   initial begin
      logic [31:0] r;
      logic [6:0]  geo;
      logic [4:0]  slot;
      logic [7:0]  off;
      bit          wr, saw_ack;
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; tb_drv = 1'b0; tb_dat = '0;
      vif.vme_a = '0; vif._vme_cmd = '0; vif._vme_geo = '0;
      set_sw = '0; qpll_lock = 1'b0; qpll_err = 1'b0;
      m_reset();

      // Reset held: everything frozen, first with quiet inputs then with noise.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("rst nrst", qpll_nrst, 0);
         check("rst reply", vif.vme_reply, 0);
         check("rst pins", pins, {8'h00, 5'h00, 7'h7F, 1'b0});
         check("rst testled", testled, 0);
         if (i >= 10) begin
            r = $urandom();
            vif.vme_a = r[22:0]; vif._vme_cmd = r[31:21]; vif._vme_geo = r[6:0];
            qpll_lock = r[7]; qpll_err = r[8]; set_sw = r[10:9];
         end
      end

      vif.vme_a = '0; vif._vme_cmd = 11'h003; vif._vme_geo = 7'h7E;
      qpll_lock = 1'b1; qpll_err = 1'b0; set_sw = 2'b10;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         check($sformatf("pwrup nrst k=%0d", k), qpll_nrst, (k >= 16));
         check($sformatf("pwrup led2 k=%0d", k), testled[2], (k >= 16));
      end
      check("qpll leds", testled[4:3], {qpll_err, qpll_lock});
      check("testled hi", testled[9:5], 0);
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(1, 9)) @(negedge clk);
         check("heartbeat", testled[1], (cyc >> HB) & 1);
      end

      vme_xact(mk_addr(5'd1, 8'h00), 7'h7E, 1'b0, 16'h0000, "id read");
      vme_xact(mk_addr(5'd1, 8'h02), 7'h7E, 1'b1, 16'h00A5, "led write");
      check("led_fp", led_fp, 8'hA5);
      vme_xact(mk_addr(5'd1, 8'h02), 7'h7E, 1'b0, 16'h0000, "led read");
      vme_xact(mk_addr(5'd1, 8'h04), 7'h7D, 1'b1, 16'h0000, "cfg nosel");
      check("cfeb kept", cfeb_clock_en, 5'h1F);
      vme_xact(mk_addr(5'd1, 8'h20), 7'h7E, 1'b1, 16'hBEEF, "unmapped write");
      vme_xact(mk_addr(5'd1, 8'h40), 7'h7E, 1'b0, 16'h0000, "unmapped read");
      vme_xact(mk_addr(5'd1, 8'h06), 7'h7E, 1'b0, 16'h0000, "status read");
      vme_xact(mk_addr(5'd1, 8'h0A), 7'h7E, 1'b0, 16'h0000, "hb read");

      for (int t = 0; t < 40; t++) begin
         r    = $urandom();
         geo  = r[6:0];
         slot = ~geo[4:0];
         if (r[9:8] == 2'b00) slot = slot ^ 5'($urandom_range(1, 31));
         if (r[12:10] < 3'd6) off = {4'h0, r[12:10], 1'b0};
         else                 off = {r[19:13], 1'b0};
         wr = r[20];
         qpll_err = r[21];
         set_sw   = r[23:22];
         vme_xact(mk_addr(slot, off), geo, wr, 16'($urandom()), $sformatf("rnd%0d", t));
      end

      // Reset landing in ACK: dtack drops at once and registers restore.
      vme_xact(mk_addr(5'd1, 8'h08), 7'h7E, 1'b1, 16'h001B, "step write");
      @(negedge clk);
      vif.vme_a = mk_addr(5'd1, 8'h04); vif._vme_geo = 7'h7E; vif._vme_cmd = 11'h001;
      tb_drv = 1'b1; tb_dat = 16'h1234;
      @(negedge clk);
      vif._vme_cmd[0] = 1'b0;
      saw_ack = 0;
      for (int k = 0; k < 8 && !saw_ack; k++) begin
         @(negedge clk);
         saw_ack = vif.vme_reply[0];
      end
      check("ack before reset", saw_ack, 1);
      #3 rst_n = 1'b0;
      #1;
      m_reset();
      check("reset dtack", vif.vme_reply, 0);
      check("reset pins", pins, m_pins());
      check("reset nrst", qpll_nrst, 0);
      repeat (3) begin
         @(negedge clk);
         check("reset hold", pins, m_pins());
      end
      vif._vme_cmd[0] = 1'b1;
      tb_drv = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      vme_xact(mk_addr(5'd1, 8'h04), 7'h7E, 1'b0, 16'h0000, "cfg after reset");
      vme_xact(mk_addr(5'd1, 8'h08), 7'h7E, 1'b0, 16'h0000, "step after reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
